// File: rtl/snowv_fsm_combine.sv
// snowv_fsm_combine: SNOW-V FSM combining stage.
//   sigma_in = R2 +32 (R3 ^ T2) to the sigma stage; z = (R1 +32 T1) ^ R2.
//   z feeds LFSR feedback (init_z) for INIT_STEPS steps, then a
//   FIFO_DEPTH-entry valid/ready keystream buffer (ks_data/ks_valid/ks_ready).
// Ports: clk, rst_n (async, active low), start, step_valid/step_ready,
//   r1/r2/r3/t1/t2, sigma_in(+_valid), init_z(+_valid), ks_data/ks_valid/
//   ks_ready, init_done; ks_count (words popped) when SNOWV_KS_COUNT_EN is defined.
module snowv_fsm_combine #(
  parameter int unsigned INIT_STEPS = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step_valid,
  output logic         step_ready,
  input  logic [127:0] r1,
  input  logic [127:0] r2,
  input  logic [127:0] r3,
  input  logic [127:0] t1,
  input  logic [127:0] t2,
  output logic [127:0] sigma_in,
  output logic         sigma_in_valid,
  output logic [127:0] init_z,
  output logic         init_z_valid,
  output logic [127:0] ks_data,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic         init_done
`ifdef SNOWV_KS_COUNT_EN
  ,
  output logic [63:0]  ks_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_KS
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            accept, push, pop;
  logic [127:0]    z, sig;

  function automatic logic [127:0] add32x4(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] s;
    s = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return s;
  endfunction

  assign z   = add32x4(r1, t1) ^ r2;
  assign sig = add32x4(r2, r3 ^ t2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // start overrides everything, including a step offered in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_ready = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_INIT: begin
        step_ready = 1'b1;
        accept     = step_valid & ~start;
        if (accept) begin
          if (cnt_q == CW'(INIT_STEPS - 1)) begin
            state_d = S_KS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_KS: begin
        step_ready = (fifo_cnt < (AW+1)'(FIFO_DEPTH));
        accept     = step_valid & step_ready & ~start;
      end
      default: ;
    endcase
    if (start) begin
      state_d = S_INIT;
      cnt_d   = '0;
    end
  end

  assign push      = accept & (state_q == S_KS);
  assign pop       = ks_valid & ks_ready;
  assign ks_valid  = (fifo_cnt != '0);
  assign ks_data   = mem[rd_ptr];
  assign init_done = (state_q == S_KS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= z;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sigma_in       <= '0;
      sigma_in_valid <= 1'b0;
      init_z         <= '0;
      init_z_valid   <= 1'b0;
    end else begin
      sigma_in_valid <= accept;
      init_z_valid   <= accept & (state_q == S_INIT);
      if (accept) sigma_in <= sig;
      if (accept && state_q == S_INIT) init_z <= z;
    end
  end

`ifdef SNOWV_KS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ks_count <= '0;
    else if (start) ks_count <= '0;
    else if (pop)   ks_count <= ks_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_snowv_fsm_combine.sv
module tb_snowv_fsm_combine;

  localparam int unsigned INIT_STEPS = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, step_valid = 1'b0, ks_ready = 1'b0;
  logic [127:0] r1 = '0, r2 = '0, r3 = '0, t1 = '0, t2 = '0;
  logic         step_ready, sigma_in_valid, init_z_valid, ks_valid, init_done;
  logic [127:0] sigma_in, init_z, ks_data;
`ifdef SNOWV_KS_COUNT_EN
  logic [63:0]  ks_count;
`endif

  snowv_fsm_combine #(.INIT_STEPS(INIT_STEPS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_valid(step_valid),
    .step_ready(step_ready), .r1(r1), .r2(r2), .r3(r3), .t1(t1), .t2(t2),
    .sigma_in(sigma_in), .sigma_in_valid(sigma_in_valid), .init_z(init_z),
    .init_z_valid(init_z_valid), .ks_data(ks_data), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .init_done(init_done)
`ifdef SNOWV_KS_COUNT_EN
    , .ks_count(ks_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs, tagged with the cycle in which they must be visible.
  typedef struct { int unsigned due; logic [127:0] d; } tagged_t;
  typedef struct {
    int unsigned due; logic rdy; logic ksv; logic [127:0] ksd; logic done; logic [63:0] kc;
  } cmb_t;

  tagged_t sq[$];
  tagged_t iq[$];
  cmb_t    cq[$];

  // Reference model: phase 0=idle 1=init 2=keystream, plus a word queue.
  int           ph = 0;
  int           icnt = 0;
  logic [127:0] mbuf[$];
  logic [63:0]  mkc = '0;

  function automatic logic [127:0] lane_add(input logic [127:0] a, input logic [127:0] b);
    logic [31:0] la[4], lb[4];
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      la[k] = a[32*k +: 32];
      lb[k] = b[32*k +: 32];
    end
    r = {la[3] + lb[3], la[2] + lb[2], la[1] + lb[1], la[0] + lb[0]};
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic st, input logic sv, input logic kr,
                       input logic [127:0] a1, input logic [127:0] a2, input logic [127:0] a3,
                       input logic [127:0] b1, input logic [127:0] b2);
    cmb_t    e;
    tagged_t t;
    logic    acc;
    @(posedge clk);
    #2;
    start = st; step_valid = sv; ks_ready = kr;
    r1 = a1; r2 = a2; r3 = a3; t1 = b1; t2 = b2;
    e.due  = cyc;
    e.rdy  = (ph == 1) || (ph == 2 && mbuf.size() < FIFO_DEPTH);
    e.ksv  = (mbuf.size() != 0);
    e.ksd  = e.ksv ? mbuf[0] : '0;
    e.done = (ph == 2);
    e.kc   = mkc;
    cq.push_back(e);
    acc = sv && e.rdy && !st;
    if (st) begin
      mbuf.delete();
      ph = 1; icnt = 0; mkc = '0;
    end else begin
      if (e.ksv && kr) begin
        void'(mbuf.pop_front());
        mkc = mkc + 64'd1;
      end
      if (acc) begin
        t.due = cyc + 1;
        t.d   = lane_add(a2, a3 ^ b2);
        sq.push_back(t);
        t.d = lane_add(a1, b1) ^ a2;
        if (ph == 1) begin
          iq.push_back(t);
          icnt++;
          if (icnt == INIT_STEPS) begin ph = 2; icnt = 0; end
        end else begin
          mbuf.push_back(t.d);
        end
      end
    end
  endtask

  task automatic drive_rnd(input logic st, input logic sv, input logic kr);
    drive(st, sv, kr, rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
  endtask

  logic [127:0] last_sigma = '0;
  logic [127:0] last_initz = '0;

  always @(negedge clk) begin
    if (cq.size() != 0 && cq[0].due == cyc) begin
      cmb_t e;
      logic expv;
      e = cq.pop_front();
      chk("step_ready", {127'b0, step_ready}, {127'b0, e.rdy});
      chk("ks_valid", {127'b0, ks_valid}, {127'b0, e.ksv});
      chk("init_done", {127'b0, init_done}, {127'b0, e.done});
      if (e.ksv) chk("ks_data", ks_data, e.ksd);
`ifdef SNOWV_KS_COUNT_EN
      chk("ks_count", {64'b0, ks_count}, {64'b0, e.kc});
`endif
      expv = (sq.size() != 0 && sq[0].due == cyc);
      chk("sigma_in_valid", {127'b0, sigma_in_valid}, {127'b0, expv});
      if (expv) last_sigma = sq.pop_front().d;
      chk("sigma_in", sigma_in, last_sigma);
      expv = (iq.size() != 0 && iq[0].due == cyc);
      chk("init_z_valid", {127'b0, init_z_valid}, {127'b0, expv});
      if (expv) last_initz = iq.pop_front().d;
      chk("init_z", init_z, last_initz);
    end
  end

  initial begin
    logic [127:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst sigma_in", sigma_in, '0);
    chk("rst sigma_in_valid", {127'b0, sigma_in_valid}, '0);
    chk("rst init_z", init_z, '0);
    chk("rst init_z_valid", {127'b0, init_z_valid}, '0);
    chk("rst ks_data", ks_data, '0);
    chk("rst ks_valid", {127'b0, ks_valid}, '0);
    chk("rst step_ready", {127'b0, step_ready}, '0);
    chk("rst init_done", {127'b0, init_done}, '0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Idle: steps are refused until start.
    drive_rnd(1'b0, 1'b1, 1'b1);
    drive_rnd(1'b1, 1'b0, 1'b0);

    // Lane carry must not cross into lane 1.
    a = '0; a[31:0] = 32'hFFFF_FFFF;
    b = '0; b[31:0] = 32'h0000_0001;
    drive(1'b0, 1'b1, 1'b0, rnd128(), a, b, rnd128(), '0);
    drive_rnd(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("carry lanes0-1", {64'b0, sigma_in[63:0]}, '0);
    chk("carry init_z_valid", {127'b0, init_z_valid}, {127'b0, 1'b1});

    // Full init sequence: z = (1+2)^4 = 7 in every lane.
    drive_rnd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < INIT_STEPS; i++)
      drive(1'b0, 1'b1, 1'b0, {4{32'd1}}, {4{32'd4}}, rnd128(), {4{32'd2}}, rnd128());
    drive_rnd(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("init_z all 7", init_z, {4{32'h0000_0007}});

    // Fill with ks_ready low, then drain.
    for (int i = 0; i < 6; i++) drive_rnd(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive_rnd(1'b0, 1'b0, 1'b1);

    // Streaming: push and pop every cycle.
    for (int i = 0; i < 20; i++) drive_rnd(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_rnd(1'b0, 1'b0, 1'b1);

    // Start with three words buffered, step coincident with start.
    for (int i = 0; i < 3; i++) drive_rnd(1'b0, 1'b1, 1'b0);
    drive_rnd(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < INIT_STEPS + 2; i++) drive_rnd(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_rnd(1'b0, 1'b0, 1'b1);
    drive_rnd(1'b1, 1'b0, 1'b1);

    // Random traffic, with occasional all-ones lanes to provoke carries.
    for (int i = 0; i < 600; i++) begin
      logic st;
      st = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0)
        drive(st, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, rnd128(), rnd128(), {4{32'h0000_0001}});
      else
        drive_rnd(st, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 3; i++) drive_rnd(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("sigma queue drained", 128'(sq.size()), '0);
    chk("init_z queue drained", 128'(iq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
